game_result_detector: RTL and testbench

- Producer of the 2-bit game result code consumed by the AI result display / animation block.
- Snapshots the 3x3 tic-tac-toe board on request and scans the 8 win lines, one per cycle.
- Resolves X win, O win, draw, or still in progress, then holds the code stable for the display path until cleared.
- Also reports the winning line index for highlight overlays.

---
 rtl/game_pkg.sv | 44 ++++
 rtl/game_result_detector_line_checker.sv | 30 +++
 rtl/game_result_detector.sv | 169 ++++++++++++++++
 tb/tb_game_result_detector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, codes and the win-line table for the game result detector.
// Imported by game_result_detector and line_checker.
package game_pkg;

    localparam logic [1:0] CELL_X = 2'b01;
    localparam logic [1:0] CELL_O = 2'b10;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam int N_CELLS = 9;
    localparam int N_LINES = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESOLVE
    } state_t;

    // One 12-bit entry per line: three 4-bit cell indices, first cell
    // in the top nibble. Entry 0 sits in the low 12 bits.
    localparam logic [N_LINES-1:0][11:0] LINE_TAB = {
        12'h246,
        12'h048,
        12'h258,
        12'h147,
        12'h036,
        12'h678,
        12'h345,
        12'h012
    };

    function automatic logic [1:0] cell_at(
        input logic [17:0] b,
        input logic [3:0]  idx
    );
        logic [17:0] s;
        s = b >> {idx, 1'b0};
        return s[1:0];
    endfunction

endpackage

// File: rtl/game_result_detector_line_checker.sv
// Combinational check of one win line against the board snapshot.
// Ports: snap (18b board), line_idx (0..7) -> x_line_full, o_line_full.
module line_checker
    import game_pkg::*;
#(
    parameter logic [1:0] X_CODE = CELL_X,
    parameter logic [1:0] O_CODE = CELL_O
) (
    input  logic [17:0] snap,
    input  logic [2:0]  line_idx,
    output logic        x_line_full,
    output logic        o_line_full
);

    logic [11:0] cells;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [1:0]  c2;

    always_comb begin
        cells = LINE_TAB[line_idx];
        c0    = cell_at(snap, cells[11:8]);
        c1    = cell_at(snap, cells[7:4]);
        c2    = cell_at(snap, cells[3:0]);
    end

    assign x_line_full = (c0 == X_CODE) && (c1 == X_CODE) && (c2 == X_CODE);
    assign o_line_full = (c0 == O_CODE) && (c1 == O_CODE) && (c2 == O_CODE);

endmodule

// File: rtl/game_result_detector.sv
// Snapshots a 3x3 board, scans the 8 win lines one per cycle and holds
// result/win_line/board_error until clear. Ports: clk, rst_n, clear,
// eval_req, board[17:0] in; busy, done, result[1:0], win_line[2:0],
// board_error out.
module game_result_detector
    import game_pkg::*;
#(
    parameter logic [1:0] X_CODE = CELL_X,
    parameter logic [1:0] O_CODE = CELL_O
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        eval_req,
    input  logic [17:0] board,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [2:0]  win_line,
    output logic        board_error
);

    state_t      state;
    state_t      state_nx;

    logic [17:0] snap;
    logic [2:0]  line_cnt;
    logic        x_win;
    logic        o_win;
    logic [2:0]  x_line;
    logic [2:0]  o_line;

    logic        x_full;
    logic        o_full;
    logic        snap_full;

    logic        start;
    logic        scan_en;
    logic        resolve;

    logic [1:0]  res_nx;
    logic [2:0]  line_nx;
    logic        err_nx;

    line_checker #(
        .X_CODE (X_CODE),
        .O_CODE (O_CODE)
    ) u_line_checker (
        .snap        (snap),
        .line_idx    (line_cnt),
        .x_line_full (x_full),
        .o_line_full (o_full)
    );

    always_comb begin
        snap_full = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if ((snap[2*i +: 2] != X_CODE) && (snap[2*i +: 2] != O_CODE))
                snap_full = 1'b0;
        end
    end

    // X takes precedence when both players own a line; the conflict is
    // flagged separately on board_error.
    always_comb begin
        res_nx  = RES_NONE;
        line_nx = '0;
        err_nx  = 1'b0;
        if (x_win && o_win) begin
            res_nx  = RES_X;
            line_nx = x_line;
            err_nx  = 1'b1;
        end else if (x_win) begin
            res_nx  = RES_X;
            line_nx = x_line;
        end else if (o_win) begin
            res_nx  = RES_O;
            line_nx = o_line;
        end else if (snap_full) begin
            res_nx  = RES_DRAW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:
                    if (start)
                        state_nx = S_SCAN;
                S_SCAN:
                    if (line_cnt == 3'(N_LINES - 1))
                        state_nx = S_RESOLVE;
                S_RESOLVE:
                    state_nx = start ? S_SCAN : S_IDLE;
                default:
                    state_nx = S_IDLE;
            endcase
        end
    end

    // A request seen on the resolve edge is taken straight away when the
    // evaluation is about to report "no result", so back-to-back requests
    // on an open game run at a fixed 9-cycle cadence.
    always_comb begin
        busy    = (state != S_IDLE);
        scan_en = !clear && (state == S_SCAN);
        resolve = !clear && (state == S_RESOLVE);
        start   = !clear && eval_req &&
                  (((state == S_IDLE) && (result == RES_NONE)) ||
                   (resolve && (res_nx == RES_NONE)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            result      <= RES_NONE;
            win_line    <= '0;
            board_error <= 1'b0;
            snap        <= '0;
            line_cnt    <= '0;
            x_win       <= 1'b0;
            o_win       <= 1'b0;
            x_line      <= '0;
            o_line      <= '0;
        end else begin
            done <= resolve;
            if (clear) begin
                result      <= RES_NONE;
                win_line    <= '0;
                board_error <= 1'b0;
            end
            if (resolve) begin
                result      <= res_nx;
                win_line    <= line_nx;
                board_error <= err_nx;
            end
            if (scan_en) begin
                line_cnt <= line_cnt + 3'd1;
                if (x_full && !x_win) begin
                    x_win  <= 1'b1;
                    x_line <= line_cnt;
                end
                if (o_full && !o_win) begin
                    o_win  <= 1'b1;
                    o_line <= line_cnt;
                end
            end
            if (start) begin
                snap     <= board;
                line_cnt <= '0;
                x_win    <= 1'b0;
                o_win    <= 1'b0;
                x_line   <= '0;
                o_line   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_game_result_detector.sv
// Directed self-checking bench for game_result_detector.
// Drives boards, checks latency, result codes, stickiness and clear.
module tb_game_result_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        eval_req;
    logic [17:0] board;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [2:0]  win_line;
    logic        board_error;

    int n_checks = 0;
    int n_fail   = 0;

    game_result_detector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .eval_req    (eval_req),
        .board       (board),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .win_line    (win_line),
        .board_error (board_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] brd(input logic [8:0] xm,
                                        input logic [8:0] om);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (xm[i])
                b[2*i +: 2] = 2'b01;
            else if (om[i])
                b[2*i +: 2] = 2'b10;
        end
        return b;
    endfunction

    task automatic kick;
        eval_req = 1'b1;
        tick();
        eval_req = 1'b0;
        chk("start_busy", 8'(busy), 8'd1);
        chk("start_done", 8'(done), 8'd0);
    endtask

    task automatic wait_scan(input int chg, input logic [17:0] b2);
        for (int j = 1; j <= 8; j++) begin
            if (j == chg)
                board = b2;
            tick();
            chk("scan_busy", 8'(busy), 8'd1);
            chk("scan_done", 8'(done), 8'd0);
            chk("scan_result", 8'(result), 8'd0);
        end
    endtask

    task automatic finish_chk(input logic [1:0] r, input logic [2:0] l,
                              input logic e, input logic again);
        if (again)
            eval_req = 1'b1;
        tick();
        eval_req = 1'b0;
        chk("done_pulse", 8'(done), 8'd1);
        chk("result", 8'(result), 8'(r));
        chk("win_line", 8'(win_line), 8'(l));
        chk("board_error", 8'(board_error), 8'(e));
        chk("busy_at_done", 8'(busy), 8'(again));
        if (!again) begin
            tick();
            chk("done_drop", 8'(done), 8'd0);
            chk("result_hold", 8'(result), 8'(r));
            chk("idle_busy", 8'(busy), 8'd0);
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_result", 8'(result), 8'd0);
        chk("clr_line", 8'(win_line), 8'd0);
        chk("clr_error", 8'(board_error), 8'd0);
        chk("clr_busy", 8'(busy), 8'd0);
        chk("clr_done", 8'(done), 8'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        eval_req = 1'b0;
        board    = '0;
        tick();
        tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_result", 8'(result), 8'd0);
        chk("rst_line", 8'(win_line), 8'd0);
        chk("rst_error", 8'(board_error), 8'd0);
        rst_n = 1'b1;
        tick();

        // X row 0, O on 3,4
        board = brd(9'h007, 9'h018);
        kick();
        wait_scan(0, '0);
        finish_chk(2'b01, 3'd0, 1'b0, 1'b0);
        do_clear();

        // O anti-diagonal; board wiped mid-scan
        board = brd(9'h00B, 9'h054);
        kick();
        wait_scan(3, '0);
        finish_chk(2'b10, 3'd7, 1'b0, 1'b0);
        do_clear();

        // full board, no line -> draw
        board = brd(9'h18D, 9'h072);
        kick();
        wait_scan(0, '0);
        finish_chk(2'b11, 3'd0, 1'b0, 1'b0);
        do_clear();

        // empty board, re-requested on the done edge
        board = '0;
        kick();
        wait_scan(0, '0);
        finish_chk(2'b00, 3'd0, 1'b0, 1'b1);
        wait_scan(0, '0);
        finish_chk(2'b00, 3'd0, 1'b0, 1'b0);

        // both players win -> X reported, error flagged
        board = brd(9'h007, 9'h1C0);
        kick();
        wait_scan(0, '0);
        finish_chk(2'b01, 3'd0, 1'b1, 1'b0);
        eval_req = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("sticky_busy", 8'(busy), 8'd0);
            chk("sticky_done", 8'(done), 8'd0);
            chk("sticky_result", 8'(result), 8'd1);
        end
        eval_req = 1'b0;
        do_clear();

        // clear aborts a scan
        board = brd(9'h007, 9'h018);
        kick();
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk("pre_abort_busy", 8'(busy), 8'd1);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", 8'(busy), 8'd0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("abort_done", 8'(done), 8'd0);
            chk("abort_result", 8'(result), 8'd0);
            chk("abort_idle", 8'(busy), 8'd0);
        end

        // clear and eval_req together
        clear    = 1'b1;
        eval_req = 1'b1;
        tick();
        clear    = 1'b0;
        eval_req = 1'b0;
        chk("clr_req_busy", 8'(busy), 8'd0);
        tick();
        chk("clr_req_busy2", 8'(busy), 8'd0);
        chk("clr_req_done", 8'(done), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
